// File: rtl/serial_mem_loader_pkg.sv
// Shared types and helpers for the serial cache load/readback port.
package serial_mem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_WDATA,
        ST_COMMIT,
        ST_RFETCH,
        ST_RWAIT,
        ST_RSHIFT,
        ST_DRAIN
    } state_t;

    localparam logic MODE_WR = 1'b1;
    localparam logic MODE_RD = 1'b0;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Header is the mode bit followed by the address.
    function automatic int hdr_w(input int addr_w);
        return 1 + addr_w;
    endfunction

endpackage

// File: rtl/serial_mem_loader_shifter.sv
// Left-shifting register with serial-in and parallel load; load wins over shift.
module serial_shifter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         shift_en,
    input  logic         sin,
    input  logic         load_en,
    input  logic [W-1:0] load_data,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load_en) begin
            q <= load_data;
        end else if (shift_en) begin
            q <= {q[W-2:0], sin};
        end
    end

endmodule

// File: rtl/serial_mem_loader.sv
// Serial MSB-first load/readback port for the instruction and data caches.
// Handshake: no valid/ready; cs_n frames a transfer, wr_en/rd_en are single-cycle strobes.
module serial_mem_loader
    import serial_mem_loader_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int NUM_TGT = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      run_i,
    input  logic [NUM_TGT-1:0]        cs_n_i,
    input  logic                      mosi_i,
    output logic                      miso_o,
    output logic [NUM_TGT-1:0]        wr_en_o,
    output logic [NUM_TGT-1:0]        rd_en_o,
    output logic [ADDR_W-1:0]         addr_o,
    output logic [DATA_W-1:0]         wdata_o,
    input  logic [NUM_TGT*DATA_W-1:0] rdata_i,
    output logic                      busy_o,
    output logic                      frame_err_o,
    output state_t                    dbg_state_o
);

    localparam int HDR_W   = hdr_w(ADDR_W);
    localparam int FRAME_W = HDR_W + DATA_W;
    localparam int CNT_W   = clog2(FRAME_W + 1);
    localparam int TGT_W   = (NUM_TGT > 1) ? clog2(NUM_TGT) : 1;
    localparam int NL_W    = clog2(NUM_TGT + 1);
    localparam int SH_W    = (DATA_W > HDR_W) ? DATA_W : HDR_W;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [TGT_W-1:0]   tgt_q;
    logic               frame_err_q;
    logic [SH_W-1:0]    sh_q, sh_next, sh_load;
    logic               sh_shift, sh_in, sh_ld;
    logic [NL_W-1:0]    n_low;
    logic [TGT_W-1:0]   low_idx;
    logic [NUM_TGT-1:0] tgt_onehot;
    logic [DATA_W-1:0]  rdata_sel;
    logic               start_ok, start_multi, abort, in_frame;
    logic               hdr_done, wdata_done, rshift_done;

    serial_shifter #(.W(SH_W)) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift_en  (sh_shift),
        .sin       (sh_in),
        .load_en   (sh_ld),
        .load_data (sh_load),
        .q         (sh_q)
    );

    always_comb begin
        n_low     = '0;
        low_idx   = '0;
        rdata_sel = '0;
        for (int i = 0; i < NUM_TGT; i++) begin
            if (!cs_n_i[i]) begin
                n_low   = n_low + NL_W'(1);
                low_idx = TGT_W'(i);
            end
            if (tgt_q == TGT_W'(i)) rdata_sel = rdata_i[i*DATA_W +: DATA_W];
        end
    end

    assign sh_next     = {sh_q[SH_W-2:0], mosi_i};
    assign tgt_onehot  = NUM_TGT'(1) << tgt_q;
    assign start_ok    = !run_i && (n_low == NL_W'(1));
    assign start_multi = !run_i && (n_low > NL_W'(1));
    // Anything other than exactly the latched target selected kills the frame.
    assign abort       = run_i || (cs_n_i != ~tgt_onehot);
    assign in_frame    = (state_q == ST_HDR) || (state_q == ST_WDATA) || (state_q == ST_RFETCH)
                      || (state_q == ST_RWAIT) || (state_q == ST_RSHIFT);
    assign hdr_done    = (cnt_q == CNT_W'(HDR_W - 1));
    assign wdata_done  = (cnt_q == CNT_W'(FRAME_W - 1));
    assign rshift_done = (cnt_q == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_ok) state_d = ST_HDR;
                       else if (start_multi) state_d = ST_DRAIN;
            ST_HDR:    if (abort) state_d = ST_DRAIN;
                       else if (hdr_done) state_d = (sh_next[ADDR_W] == MODE_WR) ? ST_WDATA : ST_RFETCH;
            ST_WDATA:  if (abort) state_d = ST_DRAIN;
                       else if (wdata_done) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_DRAIN;
            ST_RFETCH: state_d = abort ? ST_DRAIN : ST_RWAIT;
            ST_RWAIT:  state_d = abort ? ST_DRAIN : ST_RSHIFT;
            ST_RSHIFT: if (abort || rshift_done) state_d = ST_DRAIN;
            ST_DRAIN:  if (&cs_n_i) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_en_o     = (state_q == ST_COMMIT) ? tgt_onehot : '0;
        rd_en_o     = (state_q == ST_RFETCH) ? tgt_onehot : '0;
        busy_o      = (state_q != ST_IDLE);
        miso_o      = (state_q == ST_RSHIFT) && sh_q[DATA_W-1];
        frame_err_o = frame_err_q;
        dbg_state_o = state_q;
        sh_shift    = ((state_q == ST_IDLE) && start_ok) || (state_q == ST_HDR)
                   || (state_q == ST_WDATA) || (state_q == ST_RSHIFT);
        sh_in       = (state_q == ST_RSHIFT) ? 1'b0 : mosi_i;
        sh_ld       = (state_q == ST_RWAIT);
        sh_load     = SH_W'(rdata_sel);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            tgt_q       <= '0;
            addr_o      <= '0;
            wdata_o     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= ((state_q == ST_IDLE) && start_multi) || (in_frame && abort);
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (start_ok) begin
                        tgt_q <= low_idx;
                        cnt_q <= CNT_W'(1);
                    end
                end
                ST_HDR: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (hdr_done && !abort) addr_o <= sh_next[ADDR_W-1:0];
                end
                ST_WDATA: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (wdata_done && !abort) wdata_o <= sh_next[DATA_W-1:0];
                end
                ST_RSHIFT: cnt_q <= cnt_q + CNT_W'(1);
                default:   cnt_q <= '0;
            endcase
        end
    end

endmodule
